// File: rtl/fc_pkg.sv
// rtl/fc_pkg.sv - shared types and defaults for the fully-connected layer front end
package fc_pkg;

   localparam int WIDTH_D = 8;
   localparam int IN_D    = 128;

   typedef logic [WIDTH_D-1:0]          act_t;
   typedef logic [$clog2(IN_D)-1:0]     idx_t;
   typedef logic [$clog2(IN_D+1)-1:0]   len_t;

   // A frame is malformed when s_last and the final slot do not coincide.
   function automatic logic len_mismatch(input logic last, input logic at_end);
      return last != at_end;
   endfunction

endpackage

// File: rtl/fc_in_loader_if.sv
// rtl/fc_in_loader_if.sv - activation stream in, parallel frame out
interface fc_in_loader_if #(
   parameter int WIDTH = fc_pkg::WIDTH_D,
   parameter int IN    = fc_pkg::IN_D
);

   logic             s_valid;
   logic             s_ready;
   logic [WIDTH-1:0] s_data;
   logic             s_last;
   logic [WIDTH-1:0] x [0:IN-1];
   logic             x_valid;
   logic             x_ready;
   logic             err_len;

   modport master (
      output s_valid, s_data, s_last, x_ready,
      input  s_ready, x, x_valid, err_len
   );

   modport slave (
      input  s_valid, s_data, s_last, x_ready,
      output s_ready, x, x_valid, err_len
   );

endinterface

// File: rtl/fc_in_bank.sv
// rtl/fc_in_bank.sv - one ping-pong bank: IN-entry register file with full/len state
// and a zero-masked parallel read port.
module fc_in_bank
   import fc_pkg::*;
#(
   parameter int WIDTH = WIDTH_D,
   parameter int IN    = IN_D,
   localparam int IW   = $clog2(IN),
   localparam int LW   = $clog2(IN + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [IW-1:0]    wr_idx,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             close,
   input  logic [LW-1:0]    close_len,
   input  logic             clear,
   output logic             full,
   output logic [LW-1:0]    len,
   output logic [WIDTH-1:0] rd [0:IN-1]
);

   logic [WIDTH-1:0] mem [0:IN-1];

   // Payload needs no reset: everything is masked until the bank is closed full.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_idx] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full <= 1'b0;
         len  <= '0;
      end else begin
         if (clear) begin
            full <= 1'b0;
         end
         if (close) begin
            full <= 1'b1;
            len  <= close_len;
         end
      end
   end

   // Entries past len are stale from earlier frames and read back as padding zeros.
   always_comb begin
      for (int i = 0; i < IN; i++) begin
         rd[i] = (full && (i < int'(len))) ? mem[i] : '0;
      end
   end

endmodule

// File: rtl/fc_in_loader.sv
// rtl/fc_in_loader.sv - packs a valid/ready activation stream into IN-wide frames,
// ping-pong buffered so one frame fills while the other is held for the layer.
module fc_in_loader
   import fc_pkg::*;
#(
   parameter int WIDTH = WIDTH_D,
   parameter int IN    = IN_D,
   localparam int IW   = $clog2(IN),
   localparam int LW   = $clog2(IN + 1)
) (
   input  logic           clk,
   input  logic           rst_n,
   fc_in_loader_if.slave  bus
);

   logic [IW-1:0]    idx_q;
   logic             wr_bank;
   logic             rd_bank;
   logic             err_q;

   logic             full0, full1;
   logic [LW-1:0]    len0, len1;
   logic [WIDTH-1:0] rd0 [0:IN-1];
   logic [WIDTH-1:0] rd1 [0:IN-1];

   logic             accept;
   logic             at_end;
   logic             close;
   logic             release_frame;
   logic [LW-1:0]    close_len;

   assign bus.s_ready   = !(wr_bank ? full1 : full0);
   assign bus.x_valid   = rd_bank ? full1 : full0;
   assign bus.err_len   = err_q;

   assign accept        = bus.s_valid && bus.s_ready;
   assign at_end        = (idx_q == IW'(IN - 1));
   assign close         = accept && (bus.s_last || at_end);
   assign release_frame = bus.x_valid && bus.x_ready;
   assign close_len     = LW'(idx_q) + LW'(1);

   fc_in_bank #(.WIDTH(WIDTH), .IN(IN)) u_bank0 (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en     (accept && !wr_bank),
      .wr_idx    (idx_q),
      .wr_data   (bus.s_data),
      .close     (close && !wr_bank),
      .close_len (close_len),
      .clear     (release_frame && !rd_bank),
      .full      (full0),
      .len       (len0),
      .rd        (rd0)
   );

   fc_in_bank #(.WIDTH(WIDTH), .IN(IN)) u_bank1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en     (accept && wr_bank),
      .wr_idx    (idx_q),
      .wr_data   (bus.s_data),
      .close     (close && wr_bank),
      .close_len (close_len),
      .clear     (release_frame && rd_bank),
      .full      (full1),
      .len       (len1),
      .rd        (rd1)
   );

   // An empty read bank already reads as zeros, so a plain mux keeps x zero while invalid.
   always_comb begin
      for (int i = 0; i < IN; i++) begin
         bus.x[i] = rd_bank ? rd1[i] : rd0[i];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q   <= '0;
         wr_bank <= 1'b0;
         rd_bank <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         if (close) begin
            idx_q <= '0;
         end else if (accept) begin
            idx_q <= idx_q + IW'(1);
         end
         if (close) begin
            wr_bank <= !wr_bank;
         end
         if (release_frame) begin
            rd_bank <= !rd_bank;
         end
         err_q <= accept && len_mismatch(bus.s_last, at_end);
      end
   end

endmodule
